// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexes N_DIG latched digits onto an active-low segment bus with PWM brightness and leading-zero suppression
module seg_scan_n #(
    parameter int N_DIG    = 4,
    parameter int DIV_LOG2 = 16,
    parameter int BR_W     = 4
) (
    input  logic                 CLK_seg,
    input  logic                 RST_n,
    input  logic                 en,
    input  logic [4*N_DIG-1:0]   digits_in,
    input  logic [N_DIG-1:0]     dp_in,
    input  logic [N_DIG-1:0]     blank_in,
    input  logic                 hex_mode,
    input  logic                 lz_supp,
    input  logic [BR_W-1:0]      bright,
    output logic [7:0]           data_out,
    output logic [N_DIG-1:0]     seg_sel,
    output logic                 frame_tick
);
    localparam int IW = $clog2(N_DIG);
    logic [DIV_LOG2-1:0] pre_cnt;
    logic [IW-1:0]       idx;
    logic [4*N_DIG-1:0]  dig_q, eff_dig;
    logic [N_DIG-1:0]    dp_q, blank_q, eff_dp, eff_blank, supp, nxt_sel;
    logic                hex_q, lz_q, eff_hex, eff_lz, start, lit, lead;
    logic [BR_W-1:0]     br_q, eff_br;
    logic [3:0]          code;
    logic [6:0]          seg;
    logic [7:0]          nxt_data;

    function automatic logic [6:0] dec(input logic [3:0] c, input logic hex);
        case (c)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            4'd10:   dec = hex ? 7'h08 : 7'h7F;
            4'd11:   dec = hex ? 7'h03 : 7'h7F;
            4'd12:   dec = hex ? 7'h46 : 7'h7F;
            4'd13:   dec = hex ? 7'h21 : 7'h7F;
            4'd14:   dec = 7'h06;
            default: dec = hex ? 7'h0E : 7'h7F;
        endcase
    endfunction

    // First slot of a frame decodes the values being latched so the whole frame is coherent
    assign start     = (idx == IW'(N_DIG - 1)) && (pre_cnt == '0);
    assign eff_dig   = start ? digits_in : dig_q;
    assign eff_dp    = start ? dp_in : dp_q;
    assign eff_blank = start ? blank_in : blank_q;
    assign eff_hex   = start ? hex_mode : hex_q;
    assign eff_lz    = start ? lz_supp : lz_q;
    assign eff_br    = start ? bright : br_q;

    always_comb begin
        lead = eff_lz;
        supp = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            lead    = lead && (eff_dig[4*i +: 4] == 4'd0) && !eff_dp[i];
            supp[i] = lead && (i != 0);
        end
    end

    assign code     = eff_dig[4*idx +: 4];
    assign seg      = dec(code, eff_hex);
    assign lit      = pre_cnt[DIV_LOG2-1 -: BR_W] <= eff_br;
    assign nxt_sel  = lit ? {{(N_DIG-1){1'b0}}, 1'b1} << idx : '0;
    assign nxt_data = (!lit || eff_blank[idx] || supp[idx]) ? 8'hFF : {~eff_dp[idx], seg};

    always_ff @(posedge CLK_seg) begin
        if (!RST_n || !en) begin
            pre_cnt    <= '0;
            idx        <= IW'(N_DIG - 1);
            dig_q      <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            hex_q      <= 1'b0;
            lz_q       <= 1'b0;
            br_q       <= '0;
            data_out   <= 8'hFF;
            seg_sel    <= '0;
            frame_tick <= 1'b0;
        end else begin
            pre_cnt    <= pre_cnt + 1'b1;
            if (&pre_cnt)
                idx <= (idx == '0) ? IW'(N_DIG - 1) : idx - 1'b1;
            if (start) begin
                dig_q   <= digits_in;
                dp_q    <= dp_in;
                blank_q <= blank_in;
                hex_q   <= hex_mode;
                lz_q    <= lz_supp;
                br_q    <= bright;
            end
            data_out   <= nxt_data;
            seg_sel    <= nxt_sel;
            frame_tick <= start;
        end
    end
endmodule

// File: doc/seg_scan_n.md
Name: seg_scan_n

Overview:
- Parametrised successor to the team's 4-digit seven-segment scanner.
- Time-multiplexes N_DIG BCD/hex digits onto one shared active-low segment bus and a one-hot active-high digit select.
- Adds over the previous generation:
  - internal refresh prescaler
  - per-digit decimal point and blanking
  - hex/decimal decode mode
  - leading-zero suppression
  - PWM brightness
  - frame-coherent input latching
- Sits between the UART/datapath result registers and the board display pins.

Parameters:
- N_DIG, 4, number of digits scanned (2..8).
- DIV_LOG2, 16, log2 of clocks per digit slot (>= BR_W); slot length = 2**DIV_LOG2 cycles.
- BR_W, 4, width of brightness input.

Ports:
- CLK_seg  in  1  system clock; all logic on rising edge.
- RST_n  in  1  synchronous, active-low reset.
- en  in  1  scanner enable; low = display dark, counters held at start.
- digits_in  in  4*N_DIG  digit codes; [4*N_DIG-1 -: 4] is leftmost (most significant) digit.
- dp_in  in  N_DIG  decimal point request per digit, active high; bit N_DIG-1 = leftmost.
- blank_in  in  N_DIG  force digit dark, active high.
- hex_mode  in  1  1 = decode 0-F; 0 = decimal decode.
- lz_supp  in  1  1 = suppress leading zeros.
- bright  in  BR_W  brightness level.
- data_out  out  8  segments, active low: bit7 = dp, bits6..0 = g..a.
- seg_sel  out  N_DIG  one-hot digit enable, active high; bit N_DIG-1 = leftmost.
- frame_tick  out  1  one-cycle pulse at start of each frame.

Behaviour:
Reset (RST_n low at a rising edge) and en low:
- data_out = 8'hFF, seg_sel = 0, frame_tick = 0.
- Prescaler pre_cnt = 0.
- Digit index idx = N_DIG-1.
- Latched inputs cleared to 0.
- Reset mid-frame aborts the scan immediately; no partial slot completes.

Prescaler and scan order:
- pre_cnt (DIV_LOG2 bits) increments every cycle while en is high and wraps to 0.
- Slot end occurs when pre_cnt is all-ones.
- At slot end, idx decrements (N_DIG-1 down to 0, then back to N_DIG-1). Scan is leftmost digit first.

Frame latch:
- In the cycle where idx reloads to N_DIG-1 (including the first cycle after reset/en rise), latch digits_in, dp_in, blank_in, hex_mode, lz_supp and bright.
- The same cycle produces a frame_tick pulse.
- Input changes mid-frame never appear until the next frame.

Leading-zero suppression:
- Computed from latched values.
- Digit i is suppressed when lz_supp=1, its code is 0, every digit to its left is 0, and i != 0.
- The rightmost digit always shows.
- A digit with its dp set stops suppression for itself and every digit to its right.

Decode (data_out bits6..0, active low):
- 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90, shown here with bit7=1.
- hex_mode=1: A:88 b:83 C:C6 d:A1 E:86 F:8E.
- hex_mode=0: 14 -> E (86); 10-13 and 15 -> blank (FF).
- bit7 = ~dp of the current digit.
- Blanked or suppressed digit gives data_out = FF including dp, but seg_sel is still driven.

Brightness:
- Digit select is on while pre_cnt[DIV_LOG2-1 -: BR_W] <= bright_latched.
- Otherwise seg_sel = 0 and data_out = FF.
- bright = all-ones gives 100% duty; bright = 0 gives 1/2**BR_W duty.

Timing:
- data_out and seg_sel are registered.
- Both reflect idx/pre_cnt state with exactly 1-cycle latency and change in the same cycle; they are never skewed.
- seg_sel is never multi-hot.

en behaviour:
- en fall: outputs go dark on the next edge; counters return to reset values.
- en rise: first frame starts at the leftmost digit with frame_tick.

Test Plan:
- N_DIG=4, DIV_LOG2=4, BR_W=2, bright=3, hex_mode=0, digits_in=16'h1234, no dp/blank, en=1 after reset -> seg_sel cycles 8,4,2,1 with 16 cycles each; data_out F9,A4,B0,99; frame_tick every 64 cycles.
- hex_mode=1, digits_in=16'hABEF -> 88,83,86,8E. Same input with hex_mode=0 -> FF,FF,86,FF.
- lz_supp=1, digits_in=16'h0007 -> digits 3..1 give FF, digit0 gives F8. digits_in=16'h0000 -> only rightmost shows C0. dp_in=4'b0100 with 16'h0005 -> digit2 shows 40, digit1 shows C0.
- bright=1 -> within each 16-cycle slot, seg_sel active for 8 cycles (top bits 0,1), then 0 with data_out FF. bright=0 -> 4 cycles.
- Change digits_in from 16'h1111 to 16'h2222 mid-frame -> remaining digits of the frame still F9; next frame shows A4 from its first slot.
- Assert RST_n=0 for one cycle mid-slot, and separately drop en -> next edge: seg_sel=0, data_out=FF. After release, scan restarts at seg_sel=8 with frame_tick=1.
